// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//
// Sequential binary to packed 8421-BCD converter (shift-and-add-3 / double
// dabble). One operand bit is consumed per clock. A conversion is started with
// a start/busy/done handshake, and its result feeds the seven-segment decoders.
//
// Parameters
//   BIN_W   width of the binary operand (1..16)
//   DIGITS  number of BCD digits produced (1..5)
//
// Ports
//   clk       system clock, all logic on the rising edge
//   rst       synchronous, active-high reset
//   start     conversion request, sampled only while idle
//   bin_in    binary operand, captured when start is accepted
//   busy      high while a conversion is in progress
//   done      one-cycle pulse when bcd_out/overflow have just been updated
//   bcd_out   packed 8421 digits, units digit in [3:0]
//   overflow  operand exceeded 10^DIGITS-1; bcd_out then holds value mod 10^DIGITS
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [BIN_W-1:0]    bin_shift;
    logic [BCD_W-1:0]    bcd_work;
    logic                ovf_acc;
    logic [CNT_W-1:0]    cnt;

    logic                accept;
    logic                finish;

    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_shifted;
    logic [BIN_W-1:0]    bin_shifted;
    logic                carry_out;

    // Add 3 to every digit that is 5 or more, so that the following left
    // shift carries correctly into the next decimal digit. Digits are
    // adjusted independently; no carry propagates between them.
    function automatic logic [BCD_W-1:0] adjust_digits(input logic [BCD_W-1:0] w);
        logic [BCD_W-1:0] r;
        r = w;
        for (int d = 0; d < DIGITS; d++) begin
            if (w[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = w[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // One double-dabble step: adjust, then shift {bcd_work, bin_shift} left.
    // The bit pushed out of the top digit is dropped from the result (giving
    // value mod 10^DIGITS) and recorded as overflow.
    always_comb begin
        bcd_adj     = adjust_digits(bcd_work);
        carry_out   = bcd_adj[BCD_W-1];
        bcd_shifted = {bcd_adj[BCD_W-2:0], bin_shift[BIN_W-1]};
        bin_shifted = bin_shift << 1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST_CNT) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Working registers and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_shift <= '0;
            bcd_work  <= '0;
            ovf_acc   <= 1'b0;
            cnt       <= '0;
            done      <= 1'b0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                bin_shift <= bin_in;
                bcd_work  <= '0;
                ovf_acc   <= 1'b0;
                cnt       <= '0;
            end else if (state == SHIFT) begin
                bin_shift <= bin_shifted;
                bcd_work  <= bcd_shifted;
                ovf_acc   <= ovf_acc | carry_out;
                cnt       <= cnt + CNT_W'(1);
                if (finish) begin
                    bcd_out  <= bcd_shifted;
                    overflow <= ovf_acc | carry_out;
                end
            end
        end
    end

    // busy is a decode of the state register, so it is free of input paths.
    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bin_in;

    logic        busy, done, overflow;
    logic [11:0] bcd_out;
    logic        busy2, done2, overflow2;
    logic [7:0]  bcd_out2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy2), .done(done2), .bcd_out(bcd_out2), .overflow(overflow2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operand with start for one edge; afterwards we sit in the
    // first busy cycle.
    task automatic start_conv(input logic [7:0] v);
        start  = 1'b1;
        bin_in = v;
        step();
        start  = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Advance until done is seen, at most 20 edges; returns edges advanced.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic convert(input string tag, input logic [7:0] v,
                           input logic [11:0] exp_bcd, input logic exp_ovf);
        int lat;
        start_conv(v);
        wait_done(lat);
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_bcd"},     32'(bcd_out), 32'(exp_bcd));
        check({tag, "_ovf"},     32'(overflow), 32'(exp_ovf));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        step();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_bcd_hold"},   32'(bcd_out), 32'(exp_bcd));
    endtask

    initial begin
        int lat;
        logic seen;

        // Reset for two edges, outputs must be zero.
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = 8'd0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd",  32'(bcd_out), 32'd0);
        check("rst_ovf",  32'(overflow), 32'd0);
        check("rst_bcd2", 32'(bcd_out2), 32'd0);
        rst = 1'b0;
        step();

        // Basic conversions.
        convert("v0",   8'd0,   12'h000, 1'b0);
        convert("v255", 8'd255, 12'h255, 1'b0);
        check("d2_v255_bcd", 32'(bcd_out2), 32'h55);
        check("d2_v255_ovf", 32'(overflow2), 32'd1);
        convert("v99",  8'd99,  12'h099, 1'b0);
        check("d2_v99_bcd", 32'(bcd_out2), 32'h99);
        check("d2_v99_ovf", 32'(overflow2), 32'd0);
        convert("v100", 8'd100, 12'h100, 1'b0);
        convert("v9",   8'd9,   12'h009, 1'b0);

        // Start while busy is ignored.
        start_conv(8'd200);
        step();
        step();
        start  = 1'b1;
        bin_in = 8'd37;
        step();
        start  = 1'b0;
        wait_done(lat);
        check("ign_latency", 32'(lat), 32'd5);
        check("ign_bcd", 32'(bcd_out), 32'h200);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen = seen | busy | done;
        end
        check("ign_no_second_run", 32'(seen), 32'd0);

        // Back-to-back: start in the done cycle.
        start_conv(8'd9);
        wait_done(lat);
        check("b2b_first_latency", 32'(lat), 32'd8);
        check("b2b_first_bcd", 32'(bcd_out), 32'h009);
        start  = 1'b1;
        bin_in = 8'd10;
        step();
        start  = 1'b0;
        check("b2b_busy_again", 32'(busy), 32'd1);
        check("b2b_done_low",   32'(done), 32'd0);
        wait_done(lat);
        check("b2b_second_after_first", 32'(lat + 1), 32'd9);
        check("b2b_second_bcd", 32'(bcd_out), 32'h010);
        check("b2b_second_ovf", 32'(overflow), 32'd0);
        step();

        // Reset in the middle of a conversion.
        start_conv(8'd123);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd",  32'(bcd_out), 32'd0);
        check("abort_ovf",  32'(overflow), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            seen = seen | busy | done;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        convert("v45", 8'd45, 12'h045, 1'b0);

        // Two-digit instance: overflow and recovery.
        convert("v150", 8'd150, 12'h150, 1'b0);
        check("d2_v150_bcd", 32'(bcd_out2), 32'h50);
        check("d2_v150_ovf", 32'(overflow2), 32'd1);
        convert("v42", 8'd42, 12'h042, 1'b0);
        check("d2_v42_bcd", 32'(bcd_out2), 32'h42);
        check("d2_v42_ovf", 32'(overflow2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
